// File: rtl/io_uart_tx_pkg.sv
// Shared constants for the CPU-side UART transmitter: default I/O ports,
// status/control bit positions and the shifter state encodings.
package io_uart_tx_pkg;

    localparam logic [7:0] PORT_DATA_DEF = 8'h20;
    localparam logic [7:0] PORT_CTRL_DEF = 8'h21;

    localparam int ST_TXRDY   = 0;
    localparam int ST_TXEMPTY = 1;
    localparam int ST_OVR     = 2;

    localparam int CT_CLROVR  = 0;
    localparam int CT_BRK     = 1;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_START = 2'd1;
    localparam state_t S_DATA  = 2'd2;
    localparam state_t S_STOP  = 2'd3;

    // Clocks per serial bit; the caller guarantees an integer result of at least 2.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/io_uart_tx_if.sv
// CPU I/O bus slice seen by the UART transmitter: write strobe, address,
// write data, and the status byte returned for the IN mux.
interface io_uart_tx_if;
    logic       iowr;
    logic [7:0] adr;
    logic [7:0] wdata;
    logic [7:0] status;

    modport master (output iowr, output adr, output wdata, input status);
    modport slave  (input iowr, input adr, input wdata, output status);
endinterface

// File: rtl/io_fifo.sv
// Small synchronous first-word-fall-through FIFO; O_dout always shows the
// head entry. Pointers carry one extra wrap bit to tell full from empty.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_push,
    input  logic [WIDTH-1:0] I_din,
    input  logic             I_pop,
    output logic             O_full,
    output logic             O_empty,
    output logic [WIDTH-1:0] O_dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign O_empty = (r_wr_ptr == r_rd_ptr);
    assign O_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign O_dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A push while full is still legal when the head leaves in the same cycle.
    assign w_wr_en = I_push && (!O_full || I_pop);
    assign w_rd_en = I_pop && !O_empty;

    always_ff @(posedge I_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= I_din;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// CPU-driven 8N1 serial transmitter: OUTs to the data port are queued and
// shifted out LSB first on O_tx; the control port handles overrun and break.
module io_uart_tx
    import io_uart_tx_pkg::*;
#(
    parameter int         CLK_HZ     = 13_500_000,
    parameter int         BAUD       = 115_200,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] PORT_DATA  = PORT_DATA_DEF,
    parameter logic [7:0] PORT_CTRL  = PORT_CTRL_DEF
) (
    input  logic        I_clk,
    input  logic        I_rst,
    io_uart_tx_if.slave bus,
    output logic        O_tx,
    output logic        O_busy
);
    localparam int          DIV    = calc_div(CLK_HZ, BAUD);
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_ovr;
    logic        r_brk;

    logic        w_wr_data;
    logic        w_wr_ctrl;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_dout;
    logic        w_pop;
    logic        w_push;
    logic        w_bit_end;
    logic [7:0]  w_status;

    assign w_wr_data = bus.iowr && (bus.adr == PORT_DATA);
    assign w_wr_ctrl = bus.iowr && (bus.adr == PORT_CTRL);
    assign w_bit_end = (r_cnt == 16'd0);

    // The shifter takes the next byte when idle, or at the very end of a stop
    // bit so consecutive frames run with no idle gap between them.
    assign w_pop  = !w_empty &&
                    ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    assign w_push = w_wr_data && (!w_full || w_pop);

    io_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_push  (w_push),
        .I_din   (bus.wdata),
        .I_pop   (w_pop),
        .O_full  (w_full),
        .O_empty (w_empty),
        .O_dout  (w_dout)
    );

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_ovr <= 1'b0;
            r_brk <= 1'b0;
        end else begin
            if (w_wr_ctrl && bus.wdata[CT_CLROVR]) begin
                r_ovr <= 1'b0;
            end else if (w_wr_data && w_full && !w_pop) begin
                r_ovr <= 1'b1;
            end
            if (w_wr_ctrl) begin
                r_brk <= bus.wdata[CT_BRK];
            end
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_dout;
                        r_cnt   <= DIV_M1;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_bit   <= 3'd0;
                        r_cnt   <= DIV_M1;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= DIV_M1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= w_dout;
                            r_cnt   <= DIV_M1;
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Break only masks the line; the shifter keeps its timing underneath.
    assign O_tx   = r_tx && !r_brk;
    assign O_busy = (r_state != S_IDLE);

    always_comb begin
        w_status             = 8'h00;
        w_status[ST_TXRDY]   = !w_full;
        w_status[ST_TXEMPTY] = w_empty && (r_state == S_IDLE);
        w_status[ST_OVR]     = r_ovr;
    end

    assign bus.status = w_status;

endmodule
